// File: rtl/sauria_cfg_pkg.sv
// Shared build-time defaults for the SAURIA datapath blocks.
package sauria_cfg_pkg;

  // Default activation layout: 0 = overlapping im2col tiles, 1 = packed GeMM tiles.
  parameter bit DV_GEMM_BYPASS = 1'b0;

endpackage

// File: rtl/sauria_act_tile_writer.sv
// Writes an activation stream into SRAM as a sequence of row-major 2-D tiles,
// either overlapping by a halo (im2col layout) or packed back-to-back (GeMM layout).
module sauria_act_tile_writer
  import sauria_cfg_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int DIM_W       = 8,
  parameter bit GEMM_BYPASS = DV_GEMM_BYPASS
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [DIM_W-1:0]  i_tile_w,
  input  logic [DIM_W-1:0]  i_tile_h,
  input  logic [ADDR_W-1:0] i_row_stride,
  input  logic [DIM_W-1:0]  i_n_tiles,
  input  logic [DIM_W-1:0]  i_overlap,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  col_q, row_q, tile_q;
  logic [DIM_W-1:0]  col_last_q, row_last_q, tile_last_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] tile_step_q;
  logic [ADDR_W-1:0] origin_q;
  logic [ADDR_W-1:0] row_ptr_q;

  logic [DIM_W-1:0]  step_rows;
  logic [ADDR_W-1:0] step_addr;
  logic              zero_cfg;
  logic              accept;
  logic              last_col, last_row, last_tile;
  logic [ADDR_W-1:0] cur_addr;

  // Vertical distance between tile origins, in rows. An overlap that
  // swallows the whole tile clamps to a one-row step.
  always_comb begin
    step_rows = i_tile_h;
    if (!GEMM_BYPASS) begin
      if (i_overlap < i_tile_h) step_rows = i_tile_h - i_overlap;
      else                      step_rows = {{(DIM_W-1){1'b0}}, 1'b1};
    end
  end

  assign step_addr = ADDR_W'(step_rows) * i_row_stride;
  assign zero_cfg  = (i_tile_w == '0) || (i_tile_h == '0) || (i_n_tiles == '0);

  // Stream handshake: a beat transfers in any cycle where i_s_valid and
  // o_s_ready are both high; o_s_ready is high for the whole RUN state and
  // low otherwise, and the producer may raise or drop i_s_valid at will.
  assign accept    = i_s_valid && o_s_ready;
  assign last_col  = (col_q == col_last_q);
  assign last_row  = (row_q == row_last_q);
  assign last_tile = (tile_q == tile_last_q);
  assign cur_addr  = row_ptr_q + ADDR_W'(col_q);

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      o_s_ready   <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      col_last_q  <= '0;
      row_last_q  <= '0;
      tile_last_q <= '0;
      stride_q    <= '0;
      tile_step_q <= '0;
      origin_q    <= '0;
      row_ptr_q   <= '0;
    end else begin
      // One-cycle write pipeline: the beat accepted now is written next cycle.
      o_wr_en <= accept;
      if (accept) begin
        o_wr_addr <= cur_addr;
        o_wr_data <= i_s_data;
      end

      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            col_last_q  <= i_tile_w - 1'b1;
            row_last_q  <= i_tile_h - 1'b1;
            tile_last_q <= i_n_tiles - 1'b1;
            stride_q    <= i_row_stride;
            tile_step_q <= step_addr;
            origin_q    <= i_base_addr;
            row_ptr_q   <= i_base_addr;
            col_q       <= '0;
            row_q       <= '0;
            tile_q      <= '0;
            if (zero_cfg) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= S_RUN;
              o_s_ready <= 1'b1;
              o_busy    <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (accept) begin
            if (!last_col) begin
              col_q <= col_q + 1'b1;
            end else begin
              col_q <= '0;
              if (!last_row) begin
                row_q     <= row_q + 1'b1;
                row_ptr_q <= row_ptr_q + stride_q;
              end else begin
                row_q <= '0;
                if (!last_tile) begin
                  tile_q    <= tile_q + 1'b1;
                  origin_q  <= origin_q + tile_step_q;
                  row_ptr_q <= origin_q + tile_step_q;
                end else begin
                  state     <= S_FLUSH;
                  o_s_ready <= 1'b0;
                end
              end
            end
          end
        end

        S_FLUSH: begin
          state  <= S_DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end

        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          o_s_ready <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sauria_act_tile_writer.sv
// Directed bench for sauria_act_tile_writer: one overlapping-layout instance
// and one packed-layout instance driven by the same stream.
module tb_sauria_act_tile_writer;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;
  localparam int EW     = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DIM_W-1:0]  tile_w = '0, tile_h = '0, n_tiles = '0, overlap = '0;
  logic [ADDR_W-1:0] row_stride = '0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;

  logic              ready0, wr_en0, busy0, done0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_data0;
  logic [1:0]        st0;
  logic              ready1, wr_en1, busy1, done1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        st1;

  sauria_act_tile_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .GEMM_BYPASS(1'b0)) u_ovl (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_tile_w(tile_w), .i_tile_h(tile_h), .i_row_stride(row_stride), .i_n_tiles(n_tiles),
    .i_overlap(overlap), .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(ready0),
    .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0), .o_busy(busy0),
    .o_done(done0), .o_dbg_state(st0)
  );

  sauria_act_tile_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .GEMM_BYPASS(1'b1)) u_byp (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_tile_w(tile_w), .i_tile_h(tile_h), .i_row_stride(row_stride), .i_n_tiles(n_tiles),
    .i_overlap(overlap), .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(ready1),
    .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1), .o_busy(busy1),
    .o_done(done1), .o_dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] wq0[$], wq1[$], ref_q[$];
  int n_checks = 0, n_errs = 0;
  int done_cnt0 = 0, ready_hi0 = 0, bad_wr0 = 0, bad_wr1 = 0;
  int last_acc_cyc = 0;
  logic acc_prev0 = 1'b0, acc_prev1 = 1'b0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en0) wq0.push_back({wr_addr0, wr_data0});
    if (wr_en1) wq1.push_back({wr_addr1, wr_data1});
    if (rst_n) begin
      if (wr_en0 != acc_prev0) bad_wr0 <= bad_wr0 + 1;
      if (wr_en1 != acc_prev1) bad_wr1 <= bad_wr1 + 1;
      if (done0)  done_cnt0 <= done_cnt0 + 1;
      if (ready0) ready_hi0 <= ready_hi0 + 1;
      acc_prev0 <= s_valid && ready0;
      acc_prev1 <= s_valid && ready1;
    end else begin
      acc_prev0 <= 1'b0;
      acc_prev1 <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] base, input int w, input int h,
                           input logic [15:0] stride, input int n, input int ov);
    base_addr  = base;
    tile_w     = DIM_W'(w);
    tile_h     = DIM_W'(h);
    row_stride = stride;
    n_tiles    = DIM_W'(n);
    overlap    = DIM_W'(ov);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Configuration must have been captured; scramble it to prove that.
    base_addr  = 16'($urandom);
    tile_w     = 8'($urandom_range(1, 255));
    tile_h     = 8'($urandom_range(1, 255));
    row_stride = 16'($urandom);
    n_tiles    = 8'($urandom_range(1, 255));
    overlap    = 8'($urandom);
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit stall);
    bit acc = 1'b0;
    if (stall) begin
      for (int k = 0; k < 8 && $urandom_range(0, 1) == 0; k++) tick();
    end
    s_valid = 1'b1;
    s_data  = d;
    for (int g = 0; g < 50 && !acc; g++) begin
      @(negedge clk);
      acc = ready0;
      if (acc) last_acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_data  = 64'($urandom);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_job(input int n, input logic [DATA_W-1:0] d0, input bit stall);
    for (int i = 0; i < n; i++) send_beat(d0 + 64'(i), stall);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int g = 0; g < 50 && !seen; g++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        check({tag, "_latency"}, EW'(cyc - last_acc_cyc), EW'(2));
        check({tag, "_done_byp"}, EW'(done1), EW'(1));
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
    tick();
    check({tag, "_done_pulse"}, EW'(done0), EW'(0));
  endtask

  // Reference address/data sequence straight from the tile-origin formula.
  task automatic build_exp(input bit byp, input logic [15:0] base, input int w, input int h,
                           input logic [15:0] stride, input int n, input int ov,
                           input logic [DATA_W-1:0] d0);
    int step;
    int k = 0;
    logic [15:0] a;
    exp_q.delete();
    step = byp ? h : ((ov < h) ? h - ov : 1);
    for (int t = 0; t < n; t++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          a = 16'(int'(base) + t * step * int'(stride) + r * int'(stride) + c);
          exp_q.push_back({a, d0 + 64'(k)});
          k++;
        end
  endtask

  task automatic cmp_seq(input string tag, input int which);
    logic [EW-1:0] got_q[$];
    got_q = (which == 0) ? wq0 : wq1;
    check({tag, "_count"}, EW'(got_q.size()), EW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    wq0.delete();
    wq1.delete();
  endtask

  function automatic logic [EW-1:0] addr_of(input logic [EW-1:0] e);
    return EW'(e[EW-1:DATA_W]);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},   EW'({ready0, ready1}), 0);
    check({tag, "_wr_en"},   EW'({wr_en0, wr_en1}), 0);
    check({tag, "_wr_addr"}, EW'({wr_addr0, wr_addr1}), 0);
    check({tag, "_wr_data"}, EW'(wr_data0 | wr_data1), 0);
    check({tag, "_busy"},    EW'({busy0, busy1}), 0);
    check({tag, "_done"},    EW'({done0, done1}), 0);
    check({tag, "_state"},   EW'({st0, st1}), 0);
  endtask

  // ---------------- directed tests ----------------
  logic [DATA_W-1:0] mem0 [int];
  logic [DATA_W-1:0] mem1 [int];
  int rh, dc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Overlapping vs packed tiles, 4x3 tiles, two of them.
    clear_q();
    start_job(16'h0100, 4, 3, 16'd16, 2, 1);
    check("t1_busy", EW'({busy0, busy1}), EW'(2'b11));
    send_job(24, 64'hA000, 1'b0);
    wait_done("t1");
    check("t1_busy_after", EW'({busy0, busy1}), 0);
    check("t1_ovl_b12", addr_of(wq0[12]), EW'(16'h0120));
    check("t1_ovl_b23", addr_of(wq0[23]), EW'(16'h0143));
    check("t1_byp_b12", addr_of(wq1[12]), EW'(16'h0130));
    check("t1_byp_b23", addr_of(wq1[23]), EW'(16'h0153));
    build_exp(1'b0, 16'h0100, 4, 3, 16'd16, 2, 1, 64'hA000);
    cmp_seq("t1_ovl", 0);
    build_exp(1'b1, 16'h0100, 4, 3, 16'd16, 2, 1, 64'hA000);
    cmp_seq("t1_byp", 1);
    mem0.delete();
    mem1.delete();
    foreach (wq0[i]) mem0[int'(wq0[i][EW-1:DATA_W])] = wq0[i][DATA_W-1:0];
    foreach (wq1[i]) mem1[int'(wq1[i][EW-1:DATA_W])] = wq1[i][DATA_W-1:0];
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_halo_%0d", i), EW'(mem0[32'h120 + i]), EW'(64'hA000 + 64'(12 + i)));
    check("t1_ovl_distinct", EW'(mem0.num()), EW'(20));
    check("t1_byp_distinct", EW'(mem1.num()), EW'(24));

    // Packed layout under random stream stalls must match the unstalled run.
    clear_q();
    start_job(16'h0040, 2, 2, 16'd8, 3, 0);
    send_job(12, 64'hB000, 1'b0);
    wait_done("t2a");
    ref_q = wq1;
    clear_q();
    start_job(16'h0040, 2, 2, 16'd8, 3, 0);
    send_job(12, 64'hB000, 1'b1);
    wait_done("t2b");
    exp_q = ref_q;
    cmp_seq("t2_stall_vs_ref", 1);
    build_exp(1'b1, 16'h0040, 2, 2, 16'd8, 3, 0, 64'hB000);
    cmp_seq("t2_stall_model", 1);

    // Zero tile height: immediate done, nothing written, never ready.
    clear_q();
    rh = ready_hi0;
    start_job(16'h0300, 4, 0, 16'd16, 2, 0);
    check("t3_done", EW'({done0, done1}), EW'(2'b11));
    check("t3_busy", EW'({busy0, busy1}), 0);
    tick();
    check("t3_done_pulse", EW'({done0, done1}), 0);
    repeat (3) tick();
    check("t3_no_writes", EW'(wq0.size() + wq1.size()), 0);
    check("t3_no_ready", EW'(ready_hi0 - rh), 0);

    // Overlap larger than tile height clamps the step to one row.
    clear_q();
    start_job(16'h0000, 1, 3, 16'd8, 2, 5);
    send_job(6, 64'hD000, 1'b0);
    wait_done("t4");
    check("t4_ovl_origin1", addr_of(wq0[3]), EW'(16'h0008));
    check("t4_ovl_last", addr_of(wq0[5]), EW'(16'h0018));
    check("t4_byp_origin1", addr_of(wq1[3]), EW'(16'h0018));

    // Address wrap at the top of the address space.
    clear_q();
    start_job(16'hFFFE, 4, 1, 16'd16, 1, 0);
    send_job(4, 64'hE000, 1'b0);
    wait_done("t5");
    check("t5_a0", addr_of(wq0[0]), EW'(16'hFFFE));
    check("t5_a1", addr_of(wq0[1]), EW'(16'hFFFF));
    check("t5_a2", addr_of(wq0[2]), EW'(16'h0000));
    check("t5_a3", addr_of(wq0[3]), EW'(16'h0001));

    // Asynchronous reset in the middle of a 12-beat job.
    clear_q();
    start_job(16'h0500, 4, 3, 16'd16, 1, 0);
    send_job(5, 64'hF000, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("t6_abort");
    dc = done_cnt0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_no_done", EW'(done_cnt0 - dc), 0);
    check("t6_writes_before_abort", EW'(wq0.size()), EW'(4));

    // Fresh job after the abort.
    clear_q();
    start_job(16'h0200, 2, 1, 16'd8, 1, 0);
    send_job(2, 64'hC000, 1'b0);
    wait_done("t7");
    check("t7_w0", wq0[0], {16'h0200, 64'hC000});
    check("t7_w1", wq0[1], {16'h0201, 64'hC001});
    check("t7_count", EW'(wq0.size()), EW'(2));

    check("wr_en_tracks_accept_ovl", EW'(bad_wr0), 0);
    check("wr_en_tracks_accept_byp", EW'(bad_wr1), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sauria_act_tile_writer.md
Name: sauria_act_tile_writer

Overview:
- Writer-side counterpart of the data feeder's im2col read path.
- Accepts a stream of activation words and writes them into the activation SRAM as a sequence of 2-D tiles.
- Default layout: vertically consecutive tiles overlap by cfg_overlap rows, which is the layout the im2col feeder expects.
- With GEMM_BYPASS=1: tiles are packed back-to-back with no overlap, which is the GeMM-native layout the feeder reads when its im2col bypass is enabled.

Parameters:
- DATA_W, 64, SRAM word / stream width.
- ADDR_W, 16, SRAM word-address width.
- DIM_W, 8, width of tile dimension and count fields.
- GEMM_BYPASS, sauria_cfg_pkg::DV_GEMM_BYPASS, 1 = non-overlapping tile packing.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_base_addr  in  ADDR_W  word address of tile 0, row 0, col 0.
- i_tile_w  in  DIM_W  words per tile row.
- i_tile_h  in  DIM_W  rows per tile.
- i_row_stride  in  ADDR_W  address distance between rows.
- i_n_tiles  in  DIM_W  number of tiles.
- i_overlap  in  DIM_W  halo rows shared by consecutive tiles (ignored when GEMM_BYPASS=1).
- i_s_valid  in  1  stream beat valid.
- i_s_data  in  DATA_W  stream beat data.
- o_s_ready  out  1  stream ready.
- o_wr_en  out  1  SRAM write strobe.
- o_wr_addr  out  ADDR_W  SRAM write address.
- o_wr_data  out  DATA_W  SRAM write data.
- o_busy  out  1  high from the cycle after the start is accepted until done.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Clocking: single clock i_clk. Asynchronous active-low reset i_rstn.
- Reset values: o_s_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, state=IDLE, all counters 0.
- States:
  - IDLE: on i_start, register all cfg inputs. If any of tile_w, tile_h, n_tiles is 0, go to DONE; otherwise go to RUN.
  - RUN: o_s_ready=1. A beat is accepted when i_s_valid && o_s_ready. After accepting the last beat of the last tile, go to FLUSH.
  - FLUSH: one cycle, lets the final registered write retire. Then go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0, go to IDLE.
- o_busy = (state==RUN || state==FLUSH).
- i_start outside IDLE is ignored; cfg inputs may change freely after capture.
- Counters:
  - col counts 0..tile_w-1; row counts 0..tile_h-1; tile counts 0..n_tiles-1.
  - Row-major within a tile; tiles are processed in order.
  - All counters advance only on an accepted beat.
- Tile step rows:
  - GEMM_BYPASS=1: step = tile_h.
  - GEMM_BYPASS=0: step = tile_h - overlap if overlap < tile_h, else step = 1 (clamped).
- Address arithmetic:
  - tile_origin(t) = base + t*step*row_stride.
  - Per beat: addr = tile_origin + row*row_stride + col.
  - Computed incrementally: the origin accumulator adds step*row_stride (precomputed at start) per tile; the row pointer adds row_stride per row.
  - All arithmetic is modulo 2^ADDR_W (silent wrap, no error).
- Write latency: accepted beat in cycle N produces o_wr_en=1 in cycle N+1, with o_wr_addr/o_wr_data carrying that beat. o_wr_en=0 in any cycle following a non-accepted cycle.
- Address and data hold their last values when o_wr_en=0.
- Overlap semantics (GEMM_BYPASS=0): every tile is written in full. Halo rows of tile t+1 overwrite the last `overlap` rows of tile t at the same addresses. Last write wins; no merge.
- Backpressure: stream stalls (i_s_valid=0) leave all counters frozen in RUN; there is no timeout.
- o_done fires one cycle after FLUSH. For zero-dimension configs it fires in the cycle after start, with no writes at all.
- Asynchronous reset mid-operation aborts immediately. No o_done is generated, and any pending write is dropped.

Test Plan:
- GEMM_BYPASS=0, base=0x100, tile_w=4, tile_h=3, stride=16, n_tiles=2, overlap=1, beats 0..23 with no stalls -> 24 writes; tile 1 origin 0x120; beat 12 addr 0x120, beat 23 addr 0x143; 0x120..0x123 end holding beats 12..15; o_done exactly 2 cycles after beat 23 is accepted.
- Same config with GEMM_BYPASS=1 -> tile 1 origin 0x130; beat 23 addr 0x153; no address written twice.
- Random i_s_valid at 50% duty, tile_w=2, tile_h=2, n_tiles=3, bypass -> write sequence identical to the no-stall run; o_wr_en never asserted without a preceding accepted beat.
- i_tile_h=0 with start -> o_done in next cycle; o_wr_en stays 0; o_s_ready never asserted.
- overlap=5, tile_h=3, GEMM_BYPASS=0, base=0, stride=8 -> step clamped to 1; tile 1 origin 0x008.
- base=0xFFFE, tile_w=4, tile_h=1, n_tiles=1 -> addresses FFFE, FFFF, 0000, 0001.
- Deassert i_rstn after 5 beats of a 12-beat job -> all outputs 0 asynchronously; no o_done.
- A new start after release runs cleanly from the base address.
